banked_data_memory: RTL and testbench
=====================================

// Module: banked_data_memory
// PURPOSE
//  Parametrised MEM-stage data memory. Successor to the fixed single-cycle data array.
//  Word-addressed storage sits behind a byte address with a configurable base offset.
//  Adds byte-enable writes, a programmable access latency (LATENCY cycles) with a mem_ready
//  stall handshake to the hazard unit, and an out-of-range error flag.
//  Sits between the EXE/MEM pipeline register and the MEM/WB register.
// PARAMETERS
//  DATA_W     32     data word width in bits; multiple of 8
//  ADDR_W     32     byte-address width
//  DEPTH      64     number of DATA_W words
//  BASE_ADDR  1024   byte address mapped to word 0
//  LATENCY    1      cycles spent in BUSY per access; legal range 1..15
//  INIT_SEQ   1      1: reset loads data[i] = i; 0: contents untouched by reset
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         asynchronous reset, active-low
//  mem_r_en   in   1         read request; held stable by the pipeline while mem_ready=0
//  mem_w_en   in   1         write request; held stable by the pipeline while mem_ready=0
//  alu_res    in   ADDR_W    byte address
//  val_r_m    in   DATA_W    write data
//  byte_en    in   DATA_W/8  write byte lanes; bit k enables bits [8k+7:8k]
//  mem_out    out  DATA_W    read data
//  mem_ready  out  1         0 = stall the pipeline
//  mem_err    out  1         out-of-range access flag
// BEHAVIOUR
//  Reset (rst=0): state=IDLE, counter=0, rd_q=0, mem_err=0. If INIT_SEQ=1, data[i]=i.
//   Reset mid-access aborts it; no write is committed.
//  Index: idx = (alu_res - BASE_ADDR) >> log2(DATA_W/8); the low address bits are ignored.
//   In range iff alu_res >= BASE_ADDR and idx < DEPTH. Subtraction is ADDR_W-bit, no wrap-around.
//  FSM IDLE -> BUSY -> DONE -> IDLE:
//   IDLE: on req = mem_r_en|mem_w_en, capture op/idx/data/byte_en/range flag,
//    load counter with LATENCY-1, go to BUSY. With no req, stay in IDLE.
//   BUSY: decrement counter. When counter==0, commit the access and go to DONE:
//    write: merge enabled lanes into data[idx].
//    read: rd_q <= data[idx].
//   DONE: go to IDLE unconditionally.
//  mem_ready = (state==DONE) | (state==IDLE & ~req), combinational.
//   A request stalls for exactly LATENCY+1 cycles; the pipeline advances on the DONE cycle.
//  mem_out = rd_q while captured op is read and state==DONE; otherwise 0.
//  mem_err = 1 only in DONE of an out-of-range access. Such an access writes nothing
//   and returns 0.
//  r_en & w_en both high: treated as a write; mem_out=0 in DONE.
//  byte_en=0 on a write: full handshake completes; memory is unchanged.
//  Request fields are sampled only in IDLE; changes during BUSY/DONE are ignored.
// STRUCTURE
//  Constants.v adds `MEM_BASE_ADDR, `MEM_LATENCY and `MEM_STATE_W,
//   plus state encodings IDLE=0, BUSY=1, DONE=2.
//  Sub-module mem_req_fsm: state register, latency counter, capture strobe, mem_ready.
//   The top level holds the array, index/range logic, byte merge and rd_q.
// TESTING
//  1 Reset, INIT_SEQ=1, read 0x408 -> mem_ready low 2 cycles (LATENCY=1), DONE: mem_out=2, mem_err=0.
//  2 Write 0xDEADBEEF to 0x400, byte_en=4'b0101; read 0x400 -> mem_out=0x00AD00EF (word 0 was 0).
//  3 LATENCY=4, read 0x404 -> mem_ready=0 for 5 cycles, then 1 for one cycle with mem_out=1.
//  4 Read 0x3FC and 0x400+4*DEPTH -> mem_err=1 in DONE, mem_out=0; a write there leaves all words unchanged.
//  5 Write in BUSY, assert rst low -> state IDLE, mem_ready=1, target word keeps its reset value.
//  6 r_en=w_en=1, data 0x55 to 0x404, byte_en=4'hF -> mem_out=0; next read of 0x404 returns 0x55.

Source files
------------

// File: rtl/banked_data_memory_pkg.sv
// Shared definitions for the banked data memory: default base address and
// latency, the request-FSM state encoding and the latency counter width.
package banked_data_memory_pkg;

  localparam int MEM_BASE_ADDR = 1024;
  localparam int MEM_LATENCY   = 1;
  localparam int MEM_STATE_W   = 2;
  // LATENCY is at most 15, so the counter only ever holds 0..14.
  localparam int MEM_CNT_W     = 4;

  typedef enum logic [MEM_STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/banked_data_memory_req_fsm.sv
// Request sequencer for the banked data memory.
// Holds the IDLE/BUSY/DONE state and the latency counter, and tells the
// datapath when to capture a request and when to commit it.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   req          mem_r_en | mem_w_en from the pipeline
//   capture      request fields must be latched this cycle (IDLE with req)
//   commit       last BUSY cycle: perform the array access
//   done         state is DONE (result/err visible)
//   mem_ready    0 = stall the pipeline
module mem_req_fsm
  import banked_data_memory_pkg::*;
#(
  parameter int LATENCY = MEM_LATENCY
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic capture,
  output logic commit,
  output logic done,
  output logic mem_ready
);

  mem_state_e             state_q, state_d;
  logic [MEM_CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter loads LATENCY-1 so BUSY lasts exactly LATENCY cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_BUSY;
          cnt_d   = MEM_CNT_W'(LATENCY - 1);
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    capture   = (state_q == ST_IDLE) & req;
    commit    = (state_q == ST_BUSY) & (cnt_q == '0);
    done      = (state_q == ST_DONE);
    mem_ready = done | ((state_q == ST_IDLE) & ~req);
  end

endmodule

// File: rtl/banked_data_memory.sv
// MEM-stage data memory with byte-enable writes, programmable access latency,
// a mem_ready stall handshake and an out-of-range error flag.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   mem_r_en     read request (held while mem_ready=0)
//   mem_w_en     write request (held while mem_ready=0); wins over mem_r_en
//   alu_res      byte address; BASE_ADDR maps to word 0
//   val_r_m      write data
//   byte_en      write lane enables, bit k covers bits [8k+7:8k]
//   mem_out      read data, valid only in the DONE cycle of a read, else 0
//   mem_ready    0 = stall the pipeline
//   mem_err      1 in the DONE cycle of an out-of-range access
module banked_data_memory
  import banked_data_memory_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = MEM_BASE_ADDR,
  parameter int LATENCY   = MEM_LATENCY,
  parameter int INIT_SEQ  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_r_en,
  input  logic                mem_w_en,
  input  logic [ADDR_W-1:0]   alu_res,
  input  logic [DATA_W-1:0]   val_r_m,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic [DATA_W-1:0]   mem_out,
  output logic                mem_ready,
  output logic                mem_err
);

  localparam int LANES = DATA_W / 8;
  localparam int SHIFT = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [LANES-1:0]  be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int k = 0; k < LANES; k++)
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
    return res;
  endfunction

  logic req, capture, commit, done;

  mem_req_fsm #(.LATENCY(LATENCY)) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .capture   (capture),
    .commit    (commit),
    .done      (done),
    .mem_ready (mem_ready)
  );

  assign req = mem_r_en | mem_w_en;

  // Index/range decode; the range test guards the subtraction against wrap.
  logic [ADDR_W-1:0] offset, word_off;
  logic              in_range;
  always_comb begin
    offset   = alu_res - ADDR_W'(BASE_ADDR);
    word_off = offset >> SHIFT;
    in_range = (alu_res >= ADDR_W'(BASE_ADDR)) && (word_off < ADDR_W'(DEPTH));
  end

  logic                is_wr_q, is_wr_d;
  logic                is_rd_q, is_rd_d;
  logic                in_range_q, in_range_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [LANES-1:0]    be_q, be_d;
  logic [DATA_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   data_q [DEPTH];
  logic [DATA_W-1:0]   merged_d;
  logic                wr_fire;

  always_comb begin
    is_wr_d    = is_wr_q;
    is_rd_d    = is_rd_q;
    in_range_d = in_range_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    if (capture) begin
      is_wr_d    = mem_w_en;
      is_rd_d    = mem_r_en & ~mem_w_en;
      in_range_d = in_range;
      idx_d      = word_off[IDX_W-1:0];
      wdata_d    = val_r_m;
      be_d       = byte_en;
    end
  end

  always_comb begin
    rd_d     = rd_q;
    wr_fire  = commit & is_wr_q & in_range_q;
    merged_d = merge_lanes(data_q[idx_q], wdata_q, be_q);
    if (commit && is_rd_q)
      rd_d = in_range_q ? data_q[idx_q] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_wr_q    <= 1'b0;
      is_rd_q    <= 1'b0;
      in_range_q <= 1'b0;
      rd_q       <= '0;
    end else begin
      is_wr_q    <= is_wr_d;
      is_rd_q    <= is_rd_d;
      in_range_q <= in_range_d;
      rd_q       <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
  end

  // Array: reset-initialised to data[i]=i, or left untouched by reset.
  generate
    if (INIT_SEQ != 0) begin : g_init
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < DEPTH; i++) data_q[i] <= DATA_W'(i);
        end else if (wr_fire) begin
          data_q[idx_q] <= merged_d;
        end
      end
    end else begin : g_noinit
      always_ff @(posedge clk) begin
        if (wr_fire) data_q[idx_q] <= merged_d;
      end
    end
  endgenerate

  always_comb begin
    mem_out = (done && is_rd_q) ? rd_q : '0;
    mem_err = done & ~in_range_q;
  end

endmodule

// File: tb/tb_banked_data_memory.sv
// Bench for banked_data_memory: two instances (LATENCY=1 and LATENCY=4),
// directed cases followed by randomized accesses against a word-array model.
module tb_banked_data_memory;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       r_en, w_en, ready, err;
  logic [1:0][31:0] addr, wdata, out;
  logic [1:0][3:0]  be;

  int checks = 0;
  int errors = 0;
  int lat [2] = '{1, 4};
  logic [31:0] model [2][64];

  always #5 clk = ~clk;

  banked_data_memory #(.LATENCY(1)) dut0 (
    .clk(clk), .rst(rst_n), .mem_r_en(r_en[0]), .mem_w_en(w_en[0]),
    .alu_res(addr[0]), .val_r_m(wdata[0]), .byte_en(be[0]),
    .mem_out(out[0]), .mem_ready(ready[0]), .mem_err(err[0])
  );

  banked_data_memory #(.LATENCY(4)) dut1 (
    .clk(clk), .rst(rst_n), .mem_r_en(r_en[1]), .mem_w_en(w_en[1]),
    .alu_res(addr[1]), .val_r_m(wdata[1]), .byte_en(be[1]),
    .mem_out(out[1]), .mem_ready(ready[1]), .mem_err(err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++) model[d][i] = 32'(i);
  endtask

  // One complete handshake on instance d. With pert set, the request fields
  // are scrambled once the access is under way; they must be ignored.
  task automatic access(input int d, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b, input bit pert);
    bit          inr;
    int          idx;
    logic [31:0] exp_out;
    int          stalls;
    inr     = (a >= 32'd1024) && (((a - 32'd1024) >> 2) < 32'd64);
    idx     = inr ? int'((a - 32'd1024) >> 2) : 0;
    exp_out = 32'h0;
    if (w) begin
      if (inr)
        for (int k = 0; k < 4; k++)
          if (b[k]) model[d][idx][8*k +: 8] = wd[8*k +: 8];
    end else if (r && inr) begin
      exp_out = model[d][idx];
    end
    @(negedge clk);
    r_en[d] = r; w_en[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
    #1;
    stalls = 0;
    while (ready[d] !== 1'b1 && stalls < 40) begin
      stalls++;
      @(negedge clk);
      if (pert) begin
        addr[d] = $urandom; wdata[d] = $urandom; be[d] = 4'($urandom);
      end
      #1;
    end
    check($sformatf("stall_d%0d_a%h", d, a), 32'(stalls), 32'(lat[d] + 1));
    check($sformatf("err_d%0d_a%h", d, a), 32'(err[d]), 32'(!inr));
    check($sformatf("out_d%0d_a%h", d, a), out[d], exp_out);
    r_en[d] = 1'b0; w_en[d] = 1'b0; addr[d] = '0; wdata[d] = '0; be[d] = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    r_en = '0; w_en = '0; addr = '0; wdata = '0; be = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_ready_d%0d", d), 32'(ready[d]), 32'd1);
      check($sformatf("rst_err_d%0d", d), 32'(err[d]), 32'd0);
      check($sformatf("rst_out_d%0d", d), out[d], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Reset contents, latency 1
    access(0, 1, 0, 32'h408, 32'h0, 4'h0, 0);
    // Byte-lane write then readback
    access(0, 0, 1, 32'h400, 32'hDEADBEEF, 4'b0101, 0);
    access(0, 1, 0, 32'h400, 32'h0, 4'h0, 0);
    check("lane_merge", model[0][0], 32'h00AD00EF);
    // Latency 4
    access(1, 1, 0, 32'h404, 32'h0, 4'h0, 0);
    // Out-of-range reads and writes, both instances
    for (int d = 0; d < 2; d++) begin
      access(d, 1, 0, 32'h3FC, 32'h0, 4'h0, 0);
      access(d, 1, 0, 32'h500, 32'h0, 4'h0, 0);
      access(d, 0, 1, 32'h3FC, 32'hFFFFFFFF, 4'hF, 0);
      access(d, 0, 1, 32'h500, 32'hFFFFFFFF, 4'hF, 0);
    end
    // Simultaneous read+write acts as write
    access(0, 1, 1, 32'h404, 32'h55, 4'hF, 0);
    access(0, 1, 0, 32'h404, 32'h0, 4'h0, 0);
    // Zero byte enables leave the word unchanged
    access(0, 0, 1, 32'h408, 32'hFFFFFFFF, 4'h0, 0);
    access(0, 1, 0, 32'h408, 32'h0, 4'h0, 0);

    // Reset during BUSY of a write aborts it
    @(negedge clk);
    w_en[0] = 1'b1; addr[0] = 32'h410; wdata[0] = 32'hFFFFFFFF; be[0] = 4'hF;
    @(negedge clk);
    rst_n = 1'b0;
    w_en[0] = 1'b0; addr[0] = '0; wdata[0] = '0; be[0] = '0;
    #1;
    check("abort_ready", 32'(ready[0]), 32'd1);
    check("abort_err", 32'(err[0]), 32'd0);
    check("abort_out", out[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    access(0, 1, 0, 32'h410, 32'h0, 4'h0, 0);

    // Randomized traffic, some with fields changing mid-access
    for (int n = 0; n < 80; n++) begin
      int op;
      op = $urandom_range(1, 3);
      access($urandom_range(0, 1), op[0], op[1],
             32'd960 + 32'($urandom_range(0, 383)),
             $urandom, 4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
    end

    // Full sweep of both arrays
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++)
        access(d, 1, 0, 32'h400 + 32'(4 * i), 32'h0, 4'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
